// File: rtl/kdf_hirose_present_multiblock.sv
// rtl/kdf_hirose_present_multiblock.sv - iterated Hirose-PRESENT key derivation with multi-block output (optional macro: KDF_XOR_ACCUM_EN)

module hirose_present_wrapper #(
    parameter int          DATA_WIDTH = 136,
    parameter logic [63:0] HIROSE_C   = 64'h1234567812345678
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [127:0]          digest,
    output logic                  end_signal
);
    // Message is zero-extended to whole 64-bit blocks, most significant block hashed first.
    localparam int NB = (DATA_WIDTH + 63) / 64;
    localparam int PW = NB * 64;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {C_LOAD, C_ROUND, C_FINAL, C_DONE} core_state_t;

    core_state_t   state_q, state_d;
    logic [63:0]   g_q, h_q;
    logic [63:0]   s0_q, s1_q;
    logic [127:0]  key_q;
    logic [4:0]    rnd_q;
    logic [BW-1:0] blk_q;
    logic [PW-1:0] padded;
    logic [63:0]   m_blk;
    logic [63:0]   rk, e0, e1;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i lands on 16*(i mod 4) + i/4, the closed form of the PRESENT permutation.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            y[16*(i%4) + i/4] = x[i];
        end
        return y;
    endfunction

    // PRESENT-128 key schedule step: rotate left 61, two top nibbles through the S-box, counter into bits 66..62.
    function automatic logic [127:0] key_update(input logic [127:0] k, input logic [4:0] r);
        logic [127:0] t;
        t = {k[66:0], k[127:67]};
        t[127:124] = sbox(t[127:124]);
        t[123:120] = sbox(t[123:120]);
        t[66:62]   = t[66:62] ^ r;
        return t;
    endfunction

    assign padded = PW'(data_in);
    assign rk     = key_q[127:64];
    assign e0     = s0_q ^ rk;
    assign e1     = s1_q ^ rk;

    // Select the message block currently being compressed.
    always_comb begin
        m_blk = '0;
        for (int b = 0; b < NB; b++) begin
            if (blk_q == BW'(b)) begin
                m_blk = padded[(NB-1-b)*64 +: 64];
            end
        end
    end

    // Core sequencing state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= C_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Core next state: load, 31 rounds, finalize per block, then hold in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_LOAD:  state_d = C_ROUND;
            C_ROUND: if (rnd_q == 5'd31) state_d = C_FINAL;
            C_FINAL: state_d = (blk_q == BW'(NB-1)) ? C_DONE : C_LOAD;
            default: state_d = C_DONE;
        endcase
    end

    // Two PRESENT encryptions share one key ({H, M}); plaintexts are G and G^c (Hirose).
    always_ff @(posedge clk) begin
        if (!rst) begin
            g_q   <= '0;
            h_q   <= '0;
            s0_q  <= '0;
            s1_q  <= '0;
            key_q <= '0;
            rnd_q <= '0;
            blk_q <= '0;
        end else begin
            case (state_q)
                C_LOAD: begin
                    s0_q  <= g_q;
                    s1_q  <= g_q ^ HIROSE_C;
                    key_q <= {h_q, m_blk};
                    rnd_q <= 5'd1;
                end
                C_ROUND: begin
                    s0_q  <= p_layer(s_layer(s0_q ^ rk));
                    s1_q  <= p_layer(s_layer(s1_q ^ rk));
                    key_q <= key_update(key_q, rnd_q);
                    rnd_q <= rnd_q + 5'd1;
                end
                C_FINAL: begin
                    g_q   <= e0 ^ g_q;
                    h_q   <= e1 ^ g_q ^ HIROSE_C;
                    blk_q <= blk_q + BW'(1);
                end
                default: ;
            endcase
        end
    end

    assign digest     = {g_q, h_q};
    assign end_signal = (state_q == C_DONE);

endmodule

module kdf_hirose_present_multiblock #(
    parameter int SALT_WIDTH  = 64,
    parameter int COUNT_WIDTH = 32,
    parameter int PSW_WIDTH   = 32,
    parameter int NUM_BLOCKS  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SALT_WIDTH-1:0]     salt,
    input  logic [COUNT_WIDTH-1:0]    count,
    input  logic [PSW_WIDTH-1:0]      user_password,
    output logic                      busy,
    output logic                      done,
    output logic                      key_valid,
    output logic [128*NUM_BLOCKS-1:0] key_derivated
);
    localparam int DATA_WIDTH = PSW_WIDTH + SALT_WIDTH + COUNT_WIDTH + 8;

    typedef enum logic [2:0] {IDLE, CORE_RST, HASH, UPDATE, FIN} state_t;

    state_t                    state_q, state_d;
    logic [PSW_WIDTH-1:0]      pw_q;
    logic [SALT_WIDTH-1:0]     salt_q;
    logic [COUNT_WIDTH-1:0]    eff_q;
    logic [COUNT_WIDTH-1:0]    it_q;
    logic [7:0]                blk_q;
    logic [127:0]              u_q;
    logic [128*NUM_BLOCKS-1:0] key_q;
    logic                      key_valid_q;
`ifdef KDF_XOR_ACCUM_EN
    logic [127:0]              acc_q;
`endif
    logic [127:0]              acc_next;
    logic                      last_iter;
    logic                      last_blk;
    logic                      core_rstn;
    logic [DATA_WIDTH-1:0]     core_in;
    logic [127:0]              core_digest;
    logic                      core_end;

    assign last_iter = (it_q == eff_q);
    assign last_blk  = (blk_q == 8'(NUM_BLOCKS-1));

    // First iteration hashes the latched inputs plus the 1-based block index; later ones rehash the digest.
    assign core_in = (it_q == COUNT_WIDTH'(1)) ? {pw_q, salt_q, eff_q, blk_q + 8'd1}
                                               : DATA_WIDTH'(u_q);

    // Selecting U_1 on the first iteration is what restarts the accumulator for each block.
`ifdef KDF_XOR_ACCUM_EN
    assign acc_next = (it_q == COUNT_WIDTH'(1)) ? u_q : (acc_q ^ u_q);
`else
    assign acc_next = u_q;
`endif

    // The core only runs in HASH, so every iteration starts from a freshly reset chaining state.
    assign core_rstn = rst & (state_q == HASH);

    hirose_present_wrapper #(
        .DATA_WIDTH (DATA_WIDTH),
        .HIROSE_C   (64'h1234567812345678)
    ) u_core (
        .clk        (clk),
        .rst        (core_rstn),
        .data_in    (core_in),
        .digest     (core_digest),
        .end_signal (core_end)
    );

    // Derivation state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus busy/done decode.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = CORE_RST;
            end
            CORE_RST: begin
                busy    = 1'b1;
                state_d = HASH;
            end
            HASH: begin
                busy = 1'b1;
                if (core_end) state_d = UPDATE;
            end
            UPDATE: begin
                busy    = 1'b1;
                state_d = (last_iter && last_blk) ? FIN : CORE_RST;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Input latching, digest capture, iteration/block counters and key block writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pw_q        <= '0;
            salt_q      <= '0;
            eff_q       <= '0;
            it_q        <= '0;
            blk_q       <= '0;
            u_q         <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
`ifdef KDF_XOR_ACCUM_EN
            acc_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pw_q        <= user_password;
                        salt_q      <= salt;
                        eff_q       <= (count == '0) ? COUNT_WIDTH'(1) : count;
                        it_q        <= COUNT_WIDTH'(1);
                        blk_q       <= 8'd0;
                        key_valid_q <= 1'b0;
                    end
                end
                HASH: begin
                    if (core_end) u_q <= core_digest;
                end
                UPDATE: begin
`ifdef KDF_XOR_ACCUM_EN
                    acc_q <= acc_next;
`endif
                    if (!last_iter) begin
                        it_q <= it_q + COUNT_WIDTH'(1);
                    end else begin
                        for (int b = 0; b < NUM_BLOCKS; b++) begin
                            if (blk_q == 8'(b)) key_q[128*b +: 128] <= acc_next;
                        end
                        if (!last_blk) begin
                            blk_q <= blk_q + 8'd1;
                            it_q  <= COUNT_WIDTH'(1);
                        end else begin
                            key_valid_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_valid     = key_valid_q;
    assign key_derivated = key_q;

endmodule
